// File: rtl/bot_io_defs.sv
// Shared definitions for the PicoBlaze I/O interrupt controller: register
// offsets relative to the block's base port, FSM state encoding and the
// priority helper used to pick the next interrupt source.
package bot_io_defs;

    // Largest number of request lines the register map can carry (8-bit bus).
    localparam int NUM_SRC_MAX = 8;

    // Register offsets from BASE_PORT.
    localparam logic [7:0] OFF_CAUSE   = 8'd0;
    localparam logic [7:0] OFF_PEND    = 8'd1;
    localparam logic [7:0] OFF_MASK    = 8'd2;
    localparam logic [7:0] OFF_EOI     = 8'd3;
    localparam logic [7:0] OFF_OVRN    = 8'd4;
    localparam logic [7:0] NUM_OFFSETS = 8'd5;

    // Interrupt handshake states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    // Index of the lowest set bit (index 0 has the highest priority).
    // Returns 0 for an all-zero vector; callers qualify with a request flag.
    function automatic logic [2:0] lowest_set(input logic [NUM_SRC_MAX-1:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_SRC_MAX - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_edge_capture.sv
// Per-source event capture: rising-edge detect, mask-qualified pending bit
// and sticky overrun bit, each with a write-1-to-clear input. A new event in
// the same cycle as a clear wins, so no event is ever lost to a race.
module irq_edge_capture (
    input  logic clk,
    input  logic srst,
    input  logic src,
    input  logic mask_bit,
    input  logic pend_clr,
    input  logic ovrn_clr,
    output logic pending,
    output logic overrun
);

    logic src_q;
    logic src_d;
    logic pending_q;
    logic pending_d;
    logic overrun_q;
    logic overrun_d;
    logic rise;
    logic set_pend;

    // Edge detect and next-state of the pending/overrun bits.
    always_comb begin
        rise      = src & ~src_q;
        // Masked events are dropped entirely; they never reach overrun either.
        set_pend  = rise & mask_bit;
        src_d     = src;
        pending_d = set_pend | (pending_q & ~pend_clr);
        overrun_d = (set_pend & pending_q) | (overrun_q & ~ovrn_clr);
    end

    // State registers; src_q clears at reset so a line already high fires once.
    always_ff @(posedge clk) begin
        if (srst) begin
            src_q     <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            src_q     <= src_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/bot_irq_controller.sv
// Multi-source interrupt controller for the PicoBlaze I/O subsystem.
// Captures request edges per source, arbitrates in fixed priority (index 0
// first), runs the interrupt/interrupt_ack handshake and exposes
// CAUSE/PEND/MASK/EOI/OVRN on the PicoBlaze port bus.
module bot_irq_controller
    import bot_io_defs::*;
#(
    parameter int         NUM_SRC   = 4,
    parameter logic [7:0] BASE_PORT = 8'h18
) (
    input  logic               sysclk,
    input  logic               sysreset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [7:0]         port_id,
    input  logic [7:0]         io_data_in,
    input  logic               write_strobe,
    input  logic               read_strobe,
    output logic [7:0]         rd_data,
    output logic               rd_sel,
    output logic               interrupt,
    input  logic               interrupt_ack,
    output logic               irq_busy
);

    irq_state_e         state_q;
    logic               interrupt_q;
    logic [2:0]         id_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] mask_d;
    logic [7:0]         rd_data_q;
    logic [7:0]         rd_data_d;
    logic               rd_sel_q;
    logic               rd_sel_d;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] overrun;
    logic [NUM_SRC-1:0] pend_clr;
    logic [NUM_SRC-1:0] ovrn_clr;
    logic [7:0]         pend_ext;
    logic [7:0]         ovrn_ext;
    logic [7:0]         mask_ext;
    logic [7:0]         port_off;
    logic               owned;
    logic               wr_mask;
    logic               wr_eoi;
    logic               wr_ovrn;
    logic               eoi_ends;
    logic               req;
    logic [2:0]         next_id;
    logic               in_service;

    // One edge-capture slice per request line.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            irq_edge_capture u_cap (
                .clk      (sysclk),
                .srst     (sysreset),
                .src      (irq_src[gi]),
                .mask_bit (mask_q[gi]),
                .pend_clr (pend_clr[gi]),
                .ovrn_clr (ovrn_clr[gi]),
                .pending  (pending[gi]),
                .overrun  (overrun[gi])
            );
        end
    endgenerate

    // Address decode, write qualifiers and priority selection.
    always_comb begin
        // Offset wraps below BASE_PORT, so a single compare covers both bounds.
        port_off = port_id - BASE_PORT;
        owned    = (port_off < NUM_OFFSETS);
        wr_mask  = write_strobe & owned & (port_off == OFF_MASK);
        wr_eoi   = write_strobe & owned & (port_off == OFF_EOI);
        wr_ovrn  = write_strobe & owned & (port_off == OFF_OVRN);

        pend_clr = wr_eoi  ? io_data_in[NUM_SRC-1:0] : '0;
        ovrn_clr = wr_ovrn ? io_data_in[NUM_SRC-1:0] : '0;
        mask_d   = wr_mask ? io_data_in[NUM_SRC-1:0] : mask_q;

        pend_ext = '0;
        ovrn_ext = '0;
        mask_ext = '0;
        pend_ext[NUM_SRC-1:0] = pending;
        ovrn_ext[NUM_SRC-1:0] = overrun;
        mask_ext[NUM_SRC-1:0] = mask_q;

        in_service = (state_q == ST_SERVICE);
        // Only an EOI that names the source being serviced ends service.
        eoi_ends   = wr_eoi & in_service & io_data_in[id_q];
        req        = |(pending & mask_q);
        next_id    = lowest_set(pend_ext & mask_ext);
    end

    // Interrupt handshake FSM with registered interrupt output and cause id.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state_q     <= ST_IDLE;
            interrupt_q <= 1'b0;
            id_q        <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_q     <= ST_ASSERT;
                        interrupt_q <= 1'b1;
                        id_q        <= next_id;
                    end
                end
                ST_ASSERT: begin
                    // The request is held until ack even if its pending bit
                    // was cleared meanwhile; the handshake is never withdrawn.
                    if (interrupt_ack) begin
                        state_q     <= ST_SERVICE;
                        interrupt_q <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (eoi_ends) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    interrupt_q <= 1'b0;
                end
            endcase
        end
    end

    // Read mux; evaluated every cycle from port_id so data is ready whether
    // or not read_strobe is asserted (read_strobe carries no side effects).
    always_comb begin
        rd_sel_d  = owned;
        rd_data_d = 8'h00;
        case (port_off)
            OFF_CAUSE: rd_data_d = {in_service, 4'b0000, id_q};
            OFF_PEND:  rd_data_d = pend_ext;
            OFF_MASK:  rd_data_d = mask_ext;
            OFF_OVRN:  rd_data_d = ovrn_ext;
            default:   rd_data_d = 8'h00;
        endcase
    end

    // Mask register and registered read port.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            mask_q    <= '1;
            rd_data_q <= 8'h00;
            rd_sel_q  <= 1'b0;
        end else begin
            mask_q    <= mask_d;
            rd_data_q <= rd_data_d;
            rd_sel_q  <= rd_sel_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_sel    = rd_sel_q;
    assign interrupt = interrupt_q;
    assign irq_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bot_irq_controller.sv
// Directed bench for bot_irq_controller (NUM_SRC=4, BASE_PORT=8'h18).
module tb_bot_irq_controller;

    localparam logic [7:0] P_CAUSE = 8'h18;
    localparam logic [7:0] P_PEND  = 8'h19;
    localparam logic [7:0] P_MASK  = 8'h1A;
    localparam logic [7:0] P_EOI   = 8'h1B;
    localparam logic [7:0] P_OVRN  = 8'h1C;

    logic       clk;
    logic       sysreset;
    logic [3:0] irq_src;
    logic [7:0] port_id;
    logic [7:0] io_data_in;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] rd_data;
    logic       rd_sel;
    logic       interrupt;
    logic       interrupt_ack;
    logic       irq_busy;

    int n_pass;
    int n_total;

    typedef struct {
        logic [7:0] port;
        logic [7:0] exp_data;
        logic       exp_sel;
    } rd_vec_t;

    rd_vec_t rd_tab [7];

    bot_irq_controller #(.NUM_SRC(4), .BASE_PORT(8'h18)) dut (
        .sysclk        (clk),
        .sysreset      (sysreset),
        .irq_src       (irq_src),
        .port_id       (port_id),
        .io_data_in    (io_data_in),
        .write_strobe  (write_strobe),
        .read_strobe   (read_strobe),
        .rd_data       (rd_data),
        .rd_sel        (rd_sel),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .irq_busy      (irq_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end else begin
            n_pass++;
            $display("ok   %s = %02h", name, act);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] port);
        port_id     = port;
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
    endtask

    task automatic wr(input logic [7:0] port, input logic [7:0] data);
        port_id      = port;
        io_data_in   = data;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
        port_id      = 8'h00;
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        rd_tab[0] = '{port: P_CAUSE, exp_data: 8'h00, exp_sel: 1'b1};
        rd_tab[1] = '{port: P_PEND,  exp_data: 8'h00, exp_sel: 1'b1};
        rd_tab[2] = '{port: P_MASK,  exp_data: 8'h0F, exp_sel: 1'b1};
        rd_tab[3] = '{port: P_EOI,   exp_data: 8'h00, exp_sel: 1'b1};
        rd_tab[4] = '{port: P_OVRN,  exp_data: 8'h00, exp_sel: 1'b1};
        rd_tab[5] = '{port: 8'h17,   exp_data: 8'h00, exp_sel: 1'b0};
        rd_tab[6] = '{port: 8'h1D,   exp_data: 8'h00, exp_sel: 1'b0};

        sysreset      = 1'b1;
        irq_src       = 4'h0;
        port_id       = 8'h00;
        io_data_in    = 8'h00;
        write_strobe  = 1'b0;
        read_strobe   = 1'b0;
        interrupt_ack = 1'b0;
        repeat (3) tick();
        sysreset = 1'b0;

        // 1: reset state and register map
        check("reset_interrupt", {7'd0, interrupt}, 8'h00);
        check("reset_busy", {7'd0, irq_busy}, 8'h00);
        check("reset_rd_sel", {7'd0, rd_sel}, 8'h00);
        for (int i = 0; i < 7; i++) begin
            rd(rd_tab[i].port);
            check($sformatf("rd_port_%02h_data", rd_tab[i].port), rd_data, rd_tab[i].exp_data);
            check($sformatf("rd_port_%02h_sel", rd_tab[i].port), {7'd0, rd_sel}, {7'd0, rd_tab[i].exp_sel});
        end

        // ack while idle is ignored
        ack();
        check("ack_idle_busy", {7'd0, irq_busy}, 8'h00);

        // 2: single source full handshake
        irq_src = 4'h4;
        port_id = P_PEND;
        tick();
        irq_src = 4'h0;
        check("t2_int_not_yet", {7'd0, interrupt}, 8'h00);
        tick();
        check("t2_pend", rd_data, 8'h04);
        check("t2_int_high", {7'd0, interrupt}, 8'h01);
        tick();
        check("t2_int_held", {7'd0, interrupt}, 8'h01);
        ack();
        check("t2_int_after_ack", {7'd0, interrupt}, 8'h00);
        check("t2_busy_service", {7'd0, irq_busy}, 8'h01);
        rd(P_CAUSE);
        check("t2_cause", rd_data, 8'h82);
        wr(P_EOI, 8'h04);
        rd(P_PEND);
        check("t2_pend_cleared", rd_data, 8'h00);
        check("t2_busy_idle", {7'd0, irq_busy}, 8'h00);

        // 3: simultaneous rises on 1 and 3, priority and min low time
        irq_src = 4'hA;
        tick();
        irq_src = 4'h0;
        tick();
        check("t3_int_high", {7'd0, interrupt}, 8'h01);
        ack();
        rd(P_CAUSE);
        check("t3_cause_first", rd_data, 8'h81);
        wr(P_EOI, 8'h02);
        check("t3_int_low_gap", {7'd0, interrupt}, 8'h00);
        check("t3_busy_gap", {7'd0, irq_busy}, 8'h00);
        tick();
        check("t3_int_reassert", {7'd0, interrupt}, 8'h01);
        ack();
        rd(P_CAUSE);
        check("t3_cause_second", rd_data, 8'h83);
        wr(P_EOI, 8'h08);
        check("t3_busy_done", {7'd0, irq_busy}, 8'h00);

        // 4: masked source discarded, overrun on double rise
        wr(P_MASK, 8'h0E);
        irq_src = 4'h1;
        tick();
        irq_src = 4'h0;
        tick();
        tick();
        check("t4_masked_no_int", {7'd0, interrupt}, 8'h00);
        rd(P_PEND);
        check("t4_masked_no_pend", rd_data, 8'h00);
        irq_src = 4'h2;
        tick();
        irq_src = 4'h0;
        tick();
        check("t4_int_high", {7'd0, interrupt}, 8'h01);
        irq_src = 4'h2;
        tick();
        irq_src = 4'h0;
        rd(P_OVRN);
        check("t4_ovrn_set", rd_data, 8'h02);
        ack();
        rd(P_CAUSE);
        check("t4_cause", rd_data, 8'h81);
        wr(P_EOI, 8'h02);
        wr(P_OVRN, 8'h02);
        rd(P_OVRN);
        check("t4_ovrn_cleared", rd_data, 8'h00);
        wr(P_MASK, 8'h0F);

        // 5: EOI and new rise on the same bit in the same cycle
        irq_src = 4'h1;
        tick();
        irq_src = 4'h0;
        tick();
        check("t5_int_high", {7'd0, interrupt}, 8'h01);
        ack();
        port_id      = P_EOI;
        io_data_in   = 8'h01;
        write_strobe = 1'b1;
        irq_src      = 4'h1;
        tick();
        write_strobe = 1'b0;
        irq_src      = 4'h0;
        check("t5_idle_gap_int", {7'd0, interrupt}, 8'h00);
        check("t5_idle_gap_busy", {7'd0, irq_busy}, 8'h00);
        rd(P_PEND);
        check("t5_pend_kept", rd_data, 8'h01);
        check("t5_int_reassert", {7'd0, interrupt}, 8'h01);
        ack();
        wr(P_EOI, 8'h01);
        check("t5_busy_done", {7'd0, irq_busy}, 8'h00);

        // 6: reset while in SERVICE
        irq_src = 4'h5;
        tick();
        irq_src = 4'h0;
        tick();
        ack();
        rd(P_PEND);
        check("t6_pend_before", rd_data, 8'h05);
        check("t6_busy_before", {7'd0, irq_busy}, 8'h01);
        sysreset = 1'b1;
        tick();
        sysreset = 1'b0;
        check("t6_int_after_rst", {7'd0, interrupt}, 8'h00);
        check("t6_busy_after_rst", {7'd0, irq_busy}, 8'h00);
        rd(P_PEND);
        check("t6_pend_after_rst", rd_data, 8'h00);
        rd(P_MASK);
        check("t6_mask_after_rst", rd_data, 8'h0F);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
